// File: rtl/double_buffer_reader_if.sv
// Valid/ready word stream from the double-buffer reader to its downstream consumer.
interface double_buffer_reader_if #(
  parameter int unsigned DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] streamData;
  logic                  streamValid;
  logic                  streamReady;
  logic                  streamLast;

  modport master (
    output streamData,
    output streamValid,
    output streamLast,
    input  streamReady
  );

  modport slave (
    input  streamData,
    input  streamValid,
    input  streamLast,
    output streamReady
  );
endinterface

// File: rtl/double_buffer_reader.sv
// Drains a filled SRAM bank through a 2-entry output buffer, then releases the bank to the writer.
// Optional DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN adds a sticky overrun flag for dropped requests.
module double_buffer_reader #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     nReset,
  input  logic                     bufferFull,
  input  logic                     fullBank,
  input  logic [ADDRESS_WIDTH-1:0] wordCount,
  output logic [ADDRESS_WIDTH-1:0] sramAddress,
  input  logic [DATA_WIDTH-1:0]    sramData,
  double_buffer_reader_if.master   stream,
  output logic                     bufferReleased,
  output logic                     releasedBank,
  output logic                     busy
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
  ,
  output logic                     overrun,
  input  logic                     overrunClear
`endif
);

  localparam int unsigned IDX_W      = ADDRESS_WIDTH - 1;
  localparam int unsigned BANK_WORDS = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, RELEASE} state_t;

  state_t                   state;
  logic                     cur_bank;
  logic [ADDRESS_WIDTH-1:0] cur_count;
  logic [IDX_W-1:0]         rd_idx;
  logic                     pend_valid;
  logic                     pend_bank;
  logic [ADDRESS_WIDTH-1:0] pend_count;
  logic                     inflight;
  logic                     inflight_last;
  logic [DATA_WIDTH-1:0]    skid_data;
  logic                     skid_valid;
  logic                     skid_last;

  logic [ADDRESS_WIDTH-1:0] clamped_count_c;
  logic                     pop_c;
  logic                     head_free_c;
  logic [1:0]               occ_after_c;
  logic                     last_idx_c;
  logic                     issue_c;

  // Read credit counts words held, words arriving this edge, minus the word leaving this edge.
  always_comb begin
    clamped_count_c = wordCount;
    if (32'(wordCount) > BANK_WORDS) clamped_count_c = ADDRESS_WIDTH'(BANK_WORDS);
    pop_c       = stream.streamValid & stream.streamReady;
    head_free_c = ~stream.streamValid | pop_c;
    occ_after_c = 2'(stream.streamValid) + 2'(skid_valid) + 2'(inflight) - 2'(pop_c);
    last_idx_c  = (ADDRESS_WIDTH'(rd_idx) == cur_count - ADDRESS_WIDTH'(1));
    issue_c     = ((state == START && cur_count != '0) || state == STREAM) && (occ_after_c < 2'd2);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state              <= IDLE;
      cur_bank           <= 1'b0;
      cur_count          <= '0;
      rd_idx             <= '0;
      pend_valid         <= 1'b0;
      pend_bank          <= 1'b0;
      pend_count         <= '0;
      inflight           <= 1'b0;
      inflight_last      <= 1'b0;
      skid_data          <= '0;
      skid_valid         <= 1'b0;
      skid_last          <= 1'b0;
      sramAddress        <= '0;
      stream.streamData  <= '0;
      stream.streamValid <= 1'b0;
      stream.streamLast  <= 1'b0;
      bufferReleased     <= 1'b0;
      releasedBank       <= 1'b0;
      busy               <= 1'b0;
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
      overrun            <= 1'b0;
`endif
    end else begin
      bufferReleased <= 1'b0;

      // Bank sequencing
      case (state)
        IDLE: begin
          if (bufferFull) begin
            cur_bank  <= fullBank;
            cur_count <= clamped_count_c;
            rd_idx    <= '0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (cur_count == '0) begin
            bufferReleased <= 1'b1;
            releasedBank   <= cur_bank;
            state          <= RELEASE;
          end else begin
            state <= last_idx_c ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (issue_c && last_idx_c) state <= DRAIN;
        end
        DRAIN: begin
          if (pop_c && stream.streamLast) begin
            bufferReleased <= 1'b1;
            releasedBank   <= cur_bank;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          if (pend_valid) begin
            cur_bank  <= pend_bank;
            cur_count <= pend_count;
            rd_idx    <= '0;
            state     <= START;
          end else if (bufferFull) begin
            cur_bank  <= fullBank;
            cur_count <= clamped_count_c;
            rd_idx    <= '0;
            state     <= START;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Pending slot: one request may wait while a bank is in flight
      if (state == RELEASE && pend_valid) begin
        pend_valid <= 1'b0;
      end else if (bufferFull && state != IDLE && state != RELEASE && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_bank  <= fullBank;
        pend_count <= clamped_count_c;
      end

`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
      if (bufferFull && state != IDLE && pend_valid) overrun <= 1'b1;
      else if (overrunClear)                         overrun <= 1'b0;
`endif

      // SRAM read issue; data returns on the next edge
      if (issue_c) begin
        sramAddress   <= {cur_bank, rd_idx};
        rd_idx        <= rd_idx + IDX_W'(1);
        inflight_last <= last_idx_c;
      end
      inflight <= issue_c;

      // Two-entry output buffer: head register drives the stream, skid holds the overflow word
      if (head_free_c) begin
        if (skid_valid) begin
          stream.streamData  <= skid_data;
          stream.streamLast  <= skid_last;
          stream.streamValid <= 1'b1;
          skid_valid         <= inflight;
          if (inflight) begin
            skid_data <= sramData;
            skid_last <= inflight_last;
          end
        end else begin
          stream.streamValid <= inflight;
          if (inflight) begin
            stream.streamData <= sramData;
            stream.streamLast <= inflight_last;
          end else begin
            stream.streamLast <= 1'b0;
          end
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= sramData;
        skid_last  <= inflight_last;
      end
    end
  end

endmodule

// File: tb/tb_double_buffer_reader.sv
// Self-checking bench for double_buffer_reader: SRAM model, stream scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_double_buffer_reader;
  localparam int unsigned DW         = 10;
  localparam int unsigned AW         = 8;
  localparam int unsigned BANK_WORDS = 1 << (AW - 1);

  logic          clock = 1'b0;
  logic          nReset = 1'b0;
  logic          bufferFull = 1'b0;
  logic          fullBank = 1'b0;
  logic [AW-1:0] wordCount = '0;
  logic [AW-1:0] sramAddress;
  logic [DW-1:0] sramData;
  logic          bufferReleased;
  logic          releasedBank;
  logic          busy;
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
  logic          overrun;
  logic          overrunClear = 1'b0;
`endif

  double_buffer_reader_if #(.DATA_WIDTH(DW)) stream ();

  double_buffer_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock          (clock),
    .nReset         (nReset),
    .bufferFull     (bufferFull),
    .fullBank       (fullBank),
    .wordCount      (wordCount),
    .sramAddress    (sramAddress),
    .sramData       (sramData),
    .stream         (stream),
    .bufferReleased (bufferReleased),
    .releasedBank   (releasedBank),
    .busy           (busy)
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
    ,
    .overrun        (overrun),
    .overrunClear   (overrunClear)
`endif
  );

  always #5 clock = ~clock;

  // SRAM: address sampled on the falling edge, data seen on the next rising edge
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(negedge clock) sramData <= mem[sramAddress];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    logic          bank;
    logic [AW-1:0] cnt;
    bit            rnd;
    int            exp_words;
    int            exp_addr;
  } vec_t;

  word_t exp_q[$];
  logic  exp_rel_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    words_seen = 0;
  bit    rnd_ready = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one bufferFull pulse; accepted requests get their words and release queued
  task automatic request(input logic bank, input logic [AW-1:0] cnt, input bit accepted);
    int n;
    int addr;
    n = int'(cnt);
    if (n > int'(BANK_WORDS)) n = int'(BANK_WORDS);
    bufferFull = 1'b1;
    fullBank   = bank;
    wordCount  = cnt;
    if (accepted) begin
      for (int i = 0; i < n; i++) begin
        addr = int'(bank) * int'(BANK_WORDS) + i;
        exp_q.push_back('{data: mem[addr], last: (i == n - 1)});
      end
      exp_rel_q.push_back(bank);
    end
    @(posedge clock); #1;
    bufferFull = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0 || exp_rel_q.size() != 0) && c < budget) begin
      @(posedge clock); #1;
      c++;
    end
    check({name, "_done"}, 32'(c < budget), 1);
  endtask

  initial begin
    stream.streamReady = 1'b1;
    forever begin
      @(posedge clock); #1;
      stream.streamReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on handshake, hold-stability under stall, release order
  always @(negedge clock) begin : monitor
    word_t w;
    logic  b;
    if (!nReset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(stream.streamValid), 1);
        check("hold_data", 32'(stream.streamData), 32'(prev_data));
        check("hold_last", 32'(stream.streamLast), 32'(prev_last));
      end
      if (stream.streamValid && stream.streamReady) begin
        check("word_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("stream_data", 32'(stream.streamData), 32'(w.data));
          check("stream_last", 32'(stream.streamLast), 32'(w.last));
        end
        words_seen++;
      end
      prev_stall = stream.streamValid && !stream.streamReady;
      prev_data  = stream.streamData;
      prev_last  = stream.streamLast;
      if (bufferReleased) begin
        check("release_avail", 32'(exp_rel_q.size() != 0), 1);
        if (exp_rel_q.size() != 0) begin
          b = exp_rel_q.pop_front();
          check("released_bank", 32'(releasedBank), 32'(b));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [6];
    logic [DW-1:0] basic_exp [4];
    int            w0;
    int            c;

    vecs[0] = '{bank: 1'b0, cnt: 8'd4,   rnd: 1'b0, exp_words: 4,   exp_addr: 3};
    vecs[1] = '{bank: 1'b1, cnt: 8'd6,   rnd: 1'b1, exp_words: 6,   exp_addr: 133};
    vecs[2] = '{bank: 1'b1, cnt: 8'd200, rnd: 1'b0, exp_words: 128, exp_addr: 255};
    vecs[3] = '{bank: 1'b0, cnt: 8'd0,   rnd: 1'b0, exp_words: 0,   exp_addr: -1};
    vecs[4] = '{bank: 1'b1, cnt: 8'd128, rnd: 1'b1, exp_words: 128, exp_addr: 255};
    vecs[5] = '{bank: 1'b0, cnt: 8'd1,   rnd: 1'b1, exp_words: 1,   exp_addr: 0};
    basic_exp = '{10'h3A0, 10'h3A1, 10'h3A2, 10'h3A3};

    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a * 3 + 1);
    for (int a = 0; a < 4; a++) mem[a] = basic_exp[a];

    // Reset state
    #12;
    check("rst_addr", 32'(sramAddress), 0);
    check("rst_data", 32'(stream.streamData), 0);
    check("rst_valid", 32'(stream.streamValid), 0);
    check("rst_last", 32'(stream.streamLast), 0);
    check("rst_released", 32'(bufferReleased), 0);
    check("rst_rel_bank", 32'(releasedBank), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
    check("rst_overrun", 32'(overrun), 0);
`endif
    @(posedge clock); #1;
    nReset = 1'b1;
    @(posedge clock); #1;

    // Basic drain with cycle-exact latency
    request(1'b0, 8'd4, 1'b1);
    check("basic_busy", 32'(busy), 1);
    @(posedge clock); #1;
    check("basic_first_addr", 32'(sramAddress), 0);
    check("basic_valid_early", 32'(stream.streamValid), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check("basic_valid", 32'(stream.streamValid), 1);
      check("basic_data", 32'(stream.streamData), 32'(basic_exp[k]));
      check("basic_last", 32'(stream.streamLast), 32'(k == 3));
    end
    @(posedge clock); #1;
    check("basic_release", 32'(bufferReleased), 1);
    check("basic_rel_bank", 32'(releasedBank), 0);
    wait_done("basic", 50);

    // Empty bank: release two cycles after the request
    request(1'b1, 8'd0, 1'b1);
    check("zero_rel_early", 32'(bufferReleased), 0);
    @(posedge clock); #1;
    check("zero_release", 32'(bufferReleased), 1);
    check("zero_rel_bank", 32'(releasedBank), 1);
    @(posedge clock); #1;
    check("zero_idle", 32'(busy), 0);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      rnd_ready = vecs[v].rnd;
      w0 = words_seen;
      request(vecs[v].bank, vecs[v].cnt, 1'b1);
      wait_done("vec", 2000);
      check("vec_words", 32'(words_seen - w0), 32'(vecs[v].exp_words));
      if (vecs[v].exp_addr >= 0) check("vec_last_addr", 32'(sramAddress), 32'(vecs[v].exp_addr));
    end
    rnd_ready = 1'b0;
    @(posedge clock); #1;

    // Back-to-back banks: second request queues while the first streams
    w0 = words_seen;
    request(1'b0, 8'd3, 1'b1);
    request(1'b1, 8'd2, 1'b1);
    c = 0;
    while (exp_rel_q.size() != 0 && c < 40) begin
      check("b2b_busy", 32'(busy), 1);
      @(posedge clock); #1;
      c++;
    end
    wait_done("b2b", 40);
    check("b2b_words", 32'(words_seen - w0), 5);

    // Reset in the middle of a bank
    w0 = words_seen;
    request(1'b0, 8'd8, 1'b1);
    c = 0;
    while (words_seen - w0 < 2 && c < 20) begin
      @(posedge clock); #1;
      c++;
    end
    check("midrst_reached", 32'(c < 20), 1);
    #2;
    nReset = 1'b0;
    #1;
    check("midrst_addr", 32'(sramAddress), 0);
    check("midrst_data", 32'(stream.streamData), 0);
    check("midrst_valid", 32'(stream.streamValid), 0);
    check("midrst_last", 32'(stream.streamLast), 0);
    check("midrst_released", 32'(bufferReleased), 0);
    check("midrst_rel_bank", 32'(releasedBank), 0);
    check("midrst_busy", 32'(busy), 0);
    exp_q.delete();
    exp_rel_q.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    nReset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    w0 = words_seen;
    request(1'b1, 8'd3, 1'b1);
    wait_done("post_rst", 40);
    check("post_rst_words", 32'(words_seen - w0), 3);

    // Three requests while busy: the third is dropped
    w0 = words_seen;
    request(1'b0, 8'd4, 1'b1);
    request(1'b1, 8'd4, 1'b1);
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
    check("overrun_pre", 32'(overrun), 0);
`endif
    request(1'b0, 8'd4, 1'b0);
`ifdef DOUBLE_BUFFER_READER_OVERRUN_DETECT_EN
    check("overrun_set", 32'(overrun), 1);
    overrunClear = 1'b1;
    @(posedge clock); #1;
    overrunClear = 1'b0;
    check("overrun_clear", 32'(overrun), 0);
`endif
    wait_done("overrun", 80);
    check("overrun_words", 32'(words_seen - w0), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
